// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types for the master engine and its bench.
// Response codes, master FSM states and the default protection value.
package axi4l_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'd0,
      EXOKAY = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } axi4l_resp_t;

   typedef enum logic [2:0] {
      IDLE,
      WR_AW_W,
      WR_B,
      RD_AR,
      RD_R,
      RSP
   } axi4l_master_state_t;

   localparam logic [2:0] AXI4L_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi4l_master_wdog.sv
// Transaction watchdog: counts busy cycles, flags expiry after TIMEOUT_CYCLES of them.
// Latency: expired is combinational from the count; the count updates on the next edge.
// Backpressure: none, it only observes the run/clear controls.
module axi4l_master_wdog #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic run,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Saturates on the last busy cycle so a stalled caller cannot wrap it.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (run && (cnt_q != LAST)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = run && (cnt_q == LAST);

endmodule

// File: rtl/axi4l_master.sv
// AXI4-Lite master: one command in, one AXI4-Lite transaction out, one response back.
// Latency: accept at cycle 0, rsp_valid at cycle 3 with a zero-wait slave; one transaction outstanding.
// Backpressure: cmd_ready only in IDLE; rsp held until rsp_ready. Watchdog under AXI4L_MASTER_TIMEOUT_EN.
module axi4l_master
   import axi4l_pkg::*;
#(
   parameter int                        AXI_ADDR_WIDTH = 32,
   parameter int                        AXI_DATA_WIDTH = 32,
   parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = AXI_ADDR_WIDTH'(32'h8000_0000),
   parameter int                        TIMEOUT_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          rst_n,

   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_write,
   input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [AXI_DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
   output axi4l_resp_t                   rsp_resp,
   output logic                          rsp_timeout,

   output logic [AXI_ADDR_WIDTH-1:0]     m_awaddr,
   output logic [2:0]                    m_awprot,
   output logic                          m_awvalid,
   input  logic                          m_awready,
   output logic [AXI_DATA_WIDTH-1:0]     m_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0]   m_wstrb,
   output logic                          m_wvalid,
   input  logic                          m_wready,
   input  logic [1:0]                    m_bresp,
   input  logic                          m_bvalid,
   output logic                          m_bready,
   output logic [AXI_ADDR_WIDTH-1:0]     m_araddr,
   output logic [2:0]                    m_arprot,
   output logic                          m_arvalid,
   input  logic                          m_arready,
   input  logic [AXI_DATA_WIDTH-1:0]     m_rdata,
   input  logic [1:0]                    m_rresp,
   input  logic                          m_rvalid,
   output logic                          m_rready
);

   localparam int STRB_W = AXI_DATA_WIDTH / 8;
   localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'(STRB_W - 1);

   axi4l_master_state_t             state_q, state_d;
   logic [AXI_ADDR_WIDTH-1:0]       addr_q, addr_d;
   logic [AXI_DATA_WIDTH-1:0]       wdata_q, wdata_d;
   logic [STRB_W-1:0]               wstrb_q, wstrb_d;
   logic                            awvalid_q, awvalid_d;
   logic                            wvalid_q, wvalid_d;
   logic [AXI_DATA_WIDTH-1:0]       rdata_q, rdata_d;
   axi4l_resp_t                     resp_q, resp_d;
   logic                            timeout_q, timeout_d;

   logic                            accept;
   logic                            busy;
   logic                            expire;
   logic [AXI_ADDR_WIDTH-1:0]       issue_addr;

   assign accept     = cmd_valid && (state_q == IDLE);
   assign busy       = (state_q != IDLE) && (state_q != RSP);
   assign issue_addr = (BASE_ADDR + cmd_addr) & ALIGN_MASK;

`ifdef AXI4L_MASTER_TIMEOUT_EN
   axi4l_master_wdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (accept),
      .run     (busy),
      .expired (expire)
   );
`else
   logic tmo_cfg_unused;
   logic busy_unused;
   assign tmo_cfg_unused = (TIMEOUT_CYCLES != 0);
   assign busy_unused    = busy;
   assign expire         = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      rdata_d   = rdata_q;
      resp_d    = resp_q;
      timeout_d = timeout_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               addr_d    = issue_addr;
               rdata_d   = '0;
               resp_d    = OKAY;
               timeout_d = 1'b0;
               if (cmd_write) begin
                  wdata_d   = cmd_wdata;
                  wstrb_d   = cmd_wstrb;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WR_AW_W;
               end else begin
                  state_d   = RD_AR;
               end
            end
         end
         // AW and W retire independently; leave once neither is pending.
         WR_AW_W: begin
            awvalid_d = awvalid_q && !m_awready;
            wvalid_d  = wvalid_q && !m_wready;
            if (!awvalid_d && !wvalid_d) begin
               state_d = WR_B;
            end
         end
         WR_B: begin
            if (m_bvalid) begin
               resp_d  = axi4l_resp_t'(m_bresp);
               state_d = RSP;
            end
         end
         RD_AR: begin
            if (m_arready) begin
               state_d = RD_R;
            end
         end
         RD_R: begin
            if (m_rvalid) begin
               rdata_d = m_rdata;
               resp_d  = axi4l_resp_t'(m_rresp);
               state_d = RSP;
            end
         end
         RSP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A handshake completing on the expiry cycle still wins over abandonment.
      if (expire && (state_d == state_q)) begin
         state_d   = RSP;
         awvalid_d = 1'b0;
         wvalid_d  = 1'b0;
         rdata_d   = '0;
         resp_d    = SLVERR;
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         rdata_q   <= '0;
         resp_q    <= OKAY;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
         timeout_q <= timeout_d;
      end
   end

   assign cmd_ready   = (state_q == IDLE);
   assign rsp_valid   = (state_q == RSP);
   assign rsp_rdata   = rdata_q;
   assign rsp_resp    = resp_q;
   assign rsp_timeout = timeout_q;

   assign m_awaddr  = addr_q;
   assign m_awprot  = AXI4L_PROT_DEFAULT;
   assign m_awvalid = awvalid_q;
   assign m_wdata   = wdata_q;
   assign m_wstrb   = wstrb_q;
   assign m_wvalid  = wvalid_q;
   assign m_bready  = (state_q == WR_B);
   assign m_araddr  = addr_q;
   assign m_arprot  = AXI4L_PROT_DEFAULT;
   assign m_arvalid = (state_q == RD_AR);
   assign m_rready  = (state_q == RD_R);

endmodule

// File: doc/axi4l_master.md
Name: axi4l_master

Overview:
Synthesizable AXI4-Lite master engine. It is the hardware successor to the bench-side AXI4-Lite driver.
- Accepts single read/write commands on a valid/ready command port.
- Offsets each address by a parametrised base, runs the AXI4-Lite transaction and returns data/response on a valid/ready response port.
- Sits between the UART control logic (or a debug bridge) and the AXI4-Lite interconnect. One transaction outstanding at a time.

Parameters:
- AXI_ADDR_WIDTH, 32, address width of cmd_addr and AW/AR channels.
- AXI_DATA_WIDTH, 32, data width; legal values 32 or 64.
- BASE_ADDR, 32'h8000_0000, added to cmd_addr before issue.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid/cmd_ready  in/out  1  command handshake
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  AXI_ADDR_WIDTH  byte offset from BASE_ADDR
- cmd_wdata  in  AXI_DATA_WIDTH  write data
- cmd_wstrb  in  AXI_DATA_WIDTH/8  write strobes
- rsp_valid/rsp_ready  out/in  1  response handshake
- rsp_rdata  out  AXI_DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  axi4l_resp_t
- rsp_timeout  out  1  transaction abandoned by watchdog
- m_awaddr/m_awprot/m_awvalid/m_awready, m_wdata/m_wstrb/m_wvalid/m_wready, m_bresp/m_bvalid/m_bready, m_araddr/m_arprot/m_arvalid/m_arready, m_rdata/m_rresp/m_rvalid/m_rready  standard AXI4-Lite master signals

Behaviour:
- Reset (async assert, sync deassert externally): state=IDLE; all m_*valid, m_bready, m_rready, rsp_valid, rsp_timeout = 0; rsp_rdata=0; rsp_resp=OKAY; address/data registers = 0.
- cmd_ready = (state==IDLE). A command is accepted on cmd_valid&&cmd_ready.
- Address: issued addr = (BASE_ADDR + cmd_addr) mod 2^AXI_ADDR_WIDTH, with the low log2(AXI_DATA_WIDTH/8) bits forced to 0. m_awprot = m_arprot = 3'b000.
- States:
  - IDLE: on write -> WR_AW_W; on read -> RD_AR.
  - WR_AW_W: m_awvalid and m_wvalid are asserted together in the cycle after acceptance. Each drops independently on its own handshake; same-cycle handshakes are legal. Valids never drop before handshake. Exit to WR_B when both handshakes are done.
  - WR_B: m_bready=1. On m_bvalid, capture bresp -> RSP.
  - RD_AR: m_arvalid=1 until m_arready -> RD_R.
  - RD_R: m_rready=1. On m_rvalid, capture rdata/rresp -> RSP.
  - RSP: rsp_valid=1, outputs held stable until rsp_ready -> IDLE. The next command cannot be accepted in that same cycle (cmd_ready rises the following cycle).
- Minimum latency with a zero-wait slave: accept at cycle 0 -> rsp_valid at cycle 3 (write: AW/W hs c1, B hs c2; read: AR hs c1, R hs c2).
- Payload fields (m_awaddr/m_wdata/m_wstrb/m_araddr) are registered at acceptance and stable while valid.
- Responses (SLVERR/DECERR) are passed through unmodified. The master never retries.
- Reset mid-transaction: all valids/readys drop immediately and the state returns to IDLE. The slave is also reset by the same rst_n.

Optional Feature:
- Macro AXI4L_MASTER_TIMEOUT_EN.
- Defined:
  - Cycle counter clears on command acceptance and increments in every state except IDLE and RSP.
  - On reaching TIMEOUT_CYCLES: all m_*valid/m_*ready forced to 0, go to RSP with rsp_resp=SLVERR, rsp_timeout=1, rsp_rdata=0.
  - This is a deliberate, documented protocol abandonment for hung-slave debug.
  - Any late B/R from the abandoned transaction is ignored, because ready stays 0 until the matching later state.
- Undefined: no counter; rsp_timeout tied 0; the master waits indefinitely.

Decomposition:
- Package axi4l_pkg (shared with the bench):
  - axi4l_resp_t enum {OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3}
  - axi4l_master_state_t enum {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP}
  - AXI4L_PROT_DEFAULT = 3'b000
- One natural sub-module: axi4l_master_wdog (counter plus expiry compare), instantiated only under AXI4L_MASTER_TIMEOUT_EN.

Test Plan:
- Write, zero-wait slave:
  - Stimulus: cmd_addr=0x10, wdata=0xDEADBEEF, wstrb=0xF.
  - Response: m_awaddr=0x80000010, m_wdata=0xDEADBEEF; rsp_valid at cycle 3 with rsp_resp=OKAY, rsp_rdata=0.
- Read, slave stalls AR 4 cycles and R 2 cycles, returns 0x12345678:
  - Response: m_arvalid held stable throughout the stall; rsp_rdata=0x12345678, OKAY.
- Write skew, m_wready 3 cycles before m_awready:
  - Response: m_wvalid drops after its handshake while m_awvalid stays high; exactly one B accepted.
- DECERR read, then rsp_ready held low 5 cycles:
  - Response: rsp_resp=DECERR held stable; cmd_ready stays 0 until 1 cycle after rsp_ready.
- Wrap and alignment:
  - Stimulus: BASE_ADDR=0xFFFF_FFF0, cmd_addr=0x13.
  - Response: m_awaddr=0x0000_0000 (0x03 aligned down).
- With AXI4L_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never asserts m_arready:
  - Response: rsp_valid with rsp_timeout=1, SLVERR at cycle 17; m_arvalid=0 from then on; next command completes normally.
- Reset asserted mid-WR_B:
  - Response: all outputs return to reset values asynchronously.
